// File: rtl/vending_pkg.sv
// Shared types and defaults for the vending-machine controller.
//   state_e             : controller state encoding (REFUND always encoded)
//   DISP_CYCLES_DEFAULT : default dispense pulse length in clock cycles
package vending_pkg;

    typedef enum logic [2:0] {
        CLR    = 3'd0,
        WAIT   = 3'd1,
        ADD    = 3'd2,
        DISP   = 3'd3,
        REFUND = 3'd4
    } state_e;

    localparam int DISP_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/vending_ctrl_if.sv
// Board/datapath signal bundle of the vending controller.
//   coin_i     : coin-present level (asynchronous to the clock)
//   tot_lt_s_i : datapath flag, total < price
//   tot_ld_o   : datapath load strobe (total <= total + a)
//   tot_clr_o  : datapath clear strobe (total <= 0)
//   disp_o     : dispense actuator
//   busy_o     : controller not accepting coins
//   refund_o   : one-cycle refund pulse
// slave  = controller side, master = board/datapath side.
interface vending_ctrl_if;

    logic coin_i;
    logic tot_lt_s_i;
    logic tot_ld_o;
    logic tot_clr_o;
    logic disp_o;
    logic busy_o;
    logic refund_o;

    modport slave (
        input  coin_i, tot_lt_s_i,
        output tot_ld_o, tot_clr_o, disp_o, busy_o, refund_o
    );

    modport master (
        output coin_i, tot_lt_s_i,
        input  tot_ld_o, tot_clr_o, disp_o, busy_o, refund_o
    );

endinterface

// File: rtl/vending_ctrl_coin_sync.sv
// coin_sync: two-flop synchronizer followed by a rising-edge detector.
// Usable for any slow asynchronous board input (coin sensor, buttons).
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (all flops cleared)
//   async_i : asynchronous level input
//   pulse_o : one-cycle pulse, two cycles after async_i rises
module coin_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic pulse_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // A held level yields a single pulse.
    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: Moore controller sequencing the vending datapath.
//   clk_i, rst_ni : clock, asynchronous active-low reset (state -> CLR)
//   io (slave)    : coin input, datapath compare flag, datapath strobes,
//                   dispense / busy / refund outputs
// Optional build macro VEND_TIMEOUT_EN: refund the credit after
// TIMEOUT_CYCLES idle cycles in WAIT. Without it refund_o is tied low
// and WAIT waits indefinitely.
module vending_ctrl
    import vending_pkg::*;
#(
    parameter int DISP_CYCLES    = DISP_CYCLES_DEFAULT,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    vending_ctrl_if.slave io
);

    localparam logic [2:0] S_CLR    = CLR;
    localparam logic [2:0] S_WAIT   = WAIT;
    localparam logic [2:0] S_ADD    = ADD;
    localparam logic [2:0] S_DISP   = DISP;
    localparam logic [2:0] S_REFUND = REFUND;

    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             coin_evt;
    logic             credit;

    coin_sync u_coin_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (io.coin_i),
        .pulse_o (coin_evt)
    );

    // One counter serves both the dispense length (DISP) and the idle
    // timeout (WAIT); the two uses never overlap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_CLR: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (coin_evt) begin
                    state_nxt = S_ADD;
                    cnt_nxt   = '0;
                end else if (!io.tot_lt_s_i) begin
                    state_nxt = S_DISP;
                    cnt_nxt   = DISP_LAST;
                end else if (credit) begin
                    if (cnt == TO_LAST) begin
                        state_nxt = S_REFUND;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            S_ADD: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_DISP: begin
                if (cnt == '0) state_nxt = S_CLR;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            S_REFUND: state_nxt = S_CLR;
            default:  state_nxt = S_CLR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_CLR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Credit marks "total is non-zero", so the idle timer only runs
    // when there is something to refund.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)              credit <= 1'b0;
        else if (state == S_ADD)  credit <= 1'b1;
        else if (state == S_CLR)  credit <= 1'b0;
    end
    assign io.refund_o = (state == S_REFUND);
`else
    assign credit      = 1'b0;
    assign io.refund_o = 1'b0;
`endif

    assign io.tot_clr_o = (state == S_CLR);
    assign io.tot_ld_o  = (state == S_ADD);
    assign io.disp_o    = (state == S_DISP);
    // Held low while in reset even though the reset state is CLR.
    assign io.busy_o    = rst_ni &
                          ((state == S_CLR) | (state == S_DISP) | (state == S_REFUND));

endmodule

// File: tb/tb_vending_ctrl.sv
module tb_vending_ctrl;
    import vending_pkg::*;

    localparam int D   = 4;
    localparam int A   = 25;
    localparam int TO  = 20;
    localparam int MAX = 8192;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vending_ctrl_if io ();

    vending_ctrl #(.DISP_CYCLES(D), .CNT_W(24), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (io)
    );

    // Board datapath: total register, adder, comparator.
    int price = 50;
    int dp_total;
    always @(posedge clk) begin
        if (io.tot_clr_o)     dp_total <= 0;
        else if (io.tot_ld_o) dp_total <= dp_total + A;
    end
    assign io.tot_lt_s_i = (dp_total < price);

    // Reference model: a timeline of expected outputs per cycle, filled in
    // whenever the controller is free and a decision is due.
    bit coin_h [0:MAX-1];
    bit e_ld   [0:MAX-1];
    bit e_clr  [0:MAX-1];
    bit e_disp [0:MAX-1];
    bit e_ref  [0:MAX-1];
    int cyc = 0, free_at = 0, m_total = 0, m_credit = 0, m_idle = 0;
    int disp_start = -100, n_ld = 0, n_vend = 0;
    int obs_ld = 0, obs_disp = 0, obs_ref = 0;
    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, o, e);
        end
    endtask

    task automatic check_outs();
        chk("ld", 32'(io.tot_ld_o), 32'(e_ld[cyc]));
        chk("clr", 32'(io.tot_clr_o), 32'(e_clr[cyc]));
        chk("disp", 32'(io.disp_o), 32'(e_disp[cyc]));
        chk("busy", 32'(io.busy_o), 32'(e_disp[cyc] | e_clr[cyc] | e_ref[cyc]));
        chk("refund", 32'(io.refund_o), 32'(e_ref[cyc]));
        if (cyc >= free_at) chk("total", 32'(dp_total), 32'(m_total));
        obs_ld   += int'(io.tot_ld_o);
        obs_disp += int'(io.disp_o);
        obs_ref  += int'(io.refund_o);
    endtask

    task automatic model_step();
        bit evt;
        if (cyc < free_at || cyc < 3) return;
        evt = coin_h[cyc-2] && !coin_h[cyc-3];
        if (evt) begin
            e_ld[cyc+1] = 1'b1;
            m_total += A; n_ld++;
            free_at = cyc + 2; m_credit = 1; m_idle = 0;
        end else if (m_total >= price) begin
            for (int i = 1; i <= D; i++) e_disp[cyc+i] = 1'b1;
            e_clr[cyc+D+1] = 1'b1;
            disp_start = cyc + 1;
            free_at = cyc + D + 2; m_total = 0; m_credit = 0; m_idle = 0; n_vend++;
        end
`ifdef VEND_TIMEOUT_EN
        else if (m_credit != 0) begin
            if (m_idle == TO - 1) begin
                e_ref[cyc+1] = 1'b1;
                e_clr[cyc+2] = 1'b1;
                free_at = cyc + 3; m_total = 0; m_credit = 0; m_idle = 0;
            end else m_idle++;
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk); cyc++;
        @(negedge clk);
        check_outs();
        model_step();
    endtask

    task automatic drive(input bit c);
        io.coin_i = c;
        coin_h[cyc] = c;
    endtask

    task automatic step(input bit c);
        tick();
        drive(c);
    endtask

    // Called at a negedge, after tick(); holds reset for n clock edges.
    task automatic reset_seq(input int n);
        int t0 = cyc;
        rst_n = 1'b0;
        io.coin_i = 1'b0;
        for (int i = 0; i < 3; i++) if (t0 - i >= 0) coin_h[t0-i] = 1'b0;
        #1;
        chk("rst_clr", 32'(io.tot_clr_o), 32'd1);
        chk("rst_disp", 32'(io.disp_o), 32'd0);
        chk("rst_ld", 32'(io.tot_ld_o), 32'd0);
        chk("rst_busy", 32'(io.busy_o), 32'd0);
        chk("rst_ref", 32'(io.refund_o), 32'd0);
        repeat (n) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            coin_h[cyc] = 1'b0;
            chk("rst_hold_clr", 32'(io.tot_clr_o), 32'd1);
            chk("rst_hold_disp", 32'(io.disp_o), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rel_clr", 32'(io.tot_clr_o), 32'd1);
        chk("rel_busy", 32'(io.busy_o), 32'd1);
        for (int i = t0; i < t0 + n + D + 10; i++) begin
            e_ld[i] = 0; e_clr[i] = 0; e_disp[i] = 0; e_ref[i] = 0;
        end
        free_at = cyc + 1; m_total = 0; m_credit = 0; m_idle = 0;
    endtask

    initial begin
        int l0, d0, r0, v0, hold;
        bit c, found;
        io.coin_i = 1'b0;

        // Reset and release into WAIT
        @(posedge clk); cyc = 1;
        @(negedge clk);
        reset_seq(2);
        repeat (5) step(0);

        // Two coins of 10 cycles each -> one vend
        l0 = obs_ld; d0 = obs_disp;
        repeat (2) begin
            repeat (10) step(1);
            repeat (10) step(0);
        end
        repeat (10) step(0);
        chk("two_coin_ld", 32'(obs_ld - l0), 32'd2);
        chk("two_coin_disp", 32'(obs_disp - d0), 32'(D));
        chk("two_coin_total", 32'(dp_total), 32'd0);

        // Coin held for 100 cycles -> one load, no vend
        l0 = obs_ld; d0 = obs_disp;
        repeat (100) step(1);
        repeat (10) step(0);
        chk("held_ld", 32'(obs_ld - l0), 32'd1);
        chk("held_disp", 32'(obs_disp - d0), 32'd0);
        chk("held_total", 32'(dp_total), 32'(A));

        // Second coin vends; a coin inserted during DISP is dropped
        l0 = obs_ld; d0 = obs_disp; found = 0;
        step(1); step(1); step(0);
        for (int k = 0; k < 30; k++) begin
            tick();
            if (e_disp[cyc]) begin found = 1; break; end
            drive(0);
        end
        chk("disp_seen", 32'(found), 32'd1);
        drive(1); step(1); step(1);
        repeat (20) step(0);
        chk("dispcoin_ld", 32'(obs_ld - l0), 32'd1);
        chk("dispcoin_disp", 32'(obs_disp - d0), 32'(D));
        chk("dispcoin_total", 32'(dp_total), 32'd0);

        // Reset during the second DISP cycle
        disp_start = -100; found = 0;
        repeat (3) step(1);
        repeat (10) step(0);
        repeat (3) step(1);
        drive(0);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cyc == disp_start + 1) begin found = 1; break; end
            drive(0);
        end
        chk("midvend_reached", 32'(found), 32'd1);
        reset_seq(1);
        repeat (5) step(0);
        chk("midvend_total", 32'(dp_total), 32'd0);

        // One coin then a long idle stretch
        r0 = obs_ref;
        step(1); step(1);
        repeat (1000) step(0);
`ifdef VEND_TIMEOUT_EN
        chk("idle_refunds", 32'(obs_ref - r0), 32'd1);
        chk("idle_total", 32'(dp_total), 32'd0);
`else
        chk("idle_refunds", 32'(obs_ref - r0), 32'd0);
        chk("idle_total", 32'(dp_total), 32'(A));
`endif

        // Price 0: repeated vends straight out of WAIT
        tick(); price = 0; reset_seq(1);
        d0 = obs_disp; l0 = obs_ld;
        repeat (30) step(0);
        chk("free_disp", 32'(obs_disp - d0), 32'd20);
        chk("free_ld", 32'(obs_ld - l0), 32'd0);

        // Random coin traffic at price 50
        tick(); price = 50; reset_seq(2);
        l0 = obs_ld; d0 = obs_disp; v0 = n_vend; r0 = n_ld;
        c = 0; hold = 0;
        for (int k = 0; k < 800; k++) begin
            if (hold == 0) begin
                c = !c;
                hold = c ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 15));
            end
            hold--;
            step(c);
        end
        repeat (15) step(0);
        chk("rand_ld", 32'(obs_ld - l0), 32'(n_ld - r0));
        chk("rand_disp", 32'(obs_disp - d0), 32'((n_vend - v0) * D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vending_ctrl.md
Name: vending_ctrl

Overview:
- Moore controller that sequences the vending-machine datapath (total register, adder, comparator).
- Sole driver of the datapath's tot_ld/tot_clr inputs; consumes its tot_lt_s status flag.
- Accepts an asynchronous coin-detect line and drives a timed dispense output.
- Sits between the board I/O (coin sensor, dispense actuator/LED) and the datapath, all on one clock domain.

Parameters:
- DISP_CYCLES, 4, number of clock cycles disp_o is held high per vend (>=1).
- CNT_W, 24, width of the internal dispense/timeout counter.
- TIMEOUT_CYCLES, 12000000, idle cycles with credit before refund (used only with the optional feature).

Ports:
- clk_i  input  1  system clock; all state changes on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- coin_i  input  1  coin-present level from sensor; asynchronous to clk_i.
- tot_lt_s_i  input  1  datapath flag: total < price.
- tot_ld_o  output  1  datapath load strobe (total <= total + a).
- tot_clr_o  output  1  datapath clear strobe (total <= 0).
- disp_o  output  1  dispense actuator, high DISP_CYCLES cycles.
- busy_o  output  1  high in DISP, CLR and REFUND; coins are ignored while high.
- refund_o  output  1  one-cycle refund pulse (optional feature; tied 0 when disabled).

Behaviour:
- Reset: asynchronous and active-low (rst_ni); state forced to CLR, counter=0, synchronizer flops=0.
  - Outputs while rst_ni=0: tot_clr_o=1, all other outputs 0.
- Coin path: 2-flop synchronizer on coin_i, then rising-edge detect.
  - coin_evt is a 1-cycle pulse, 2 cycles after coin_i rises.
  - A held coin_i produces exactly one event.
- States (Moore; outputs decoded from state only):
  - CLR: tot_clr_o=1, busy_o=1. Next state WAIT unconditionally.
  - WAIT: all outputs 0.
    - Priority 1: coin_evt -> ADD.
    - Priority 2: else if tot_lt_s_i=0 -> DISP, counter loaded with DISP_CYCLES-1.
    - Otherwise stay.
  - ADD: tot_ld_o=1 for exactly one cycle; next state WAIT.
    - The datapath total updates at the end of ADD, so WAIT sees the new compare result on its first cycle. No hazard cycle.
  - DISP: disp_o=1, busy_o=1. Counter decrements each cycle; at 0 -> CLR.
    - disp_o is high exactly DISP_CYCLES cycles.
- Vend sequencing:
  - Coin accepted: ADD one cycle after coin_evt.
  - Dispense starts one cycle after the WAIT cycle that sees tot_lt_s_i=0.
  - Full vend path: DISP (DISP_CYCLES) -> CLR (1) -> WAIT.
- Simultaneous coin_evt and total>=price in WAIT: the coin wins; the vend happens on the next WAIT cycle.
- Coin events arriving during ADD, DISP, CLR or REFUND are discarded, not queued.
- Price of 0 (tot_lt_s_i=0 after clear): vends immediately from WAIT, repeatedly. This is legal and not guarded.
- Reset asserted mid-DISP: disp_o drops asynchronously; total is cleared via CLR.
- Only one of tot_ld_o / tot_clr_o is ever high in a cycle.
- The controller performs no arithmetic; overflow of the total is the datapath's concern.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A credit flag is set on ADD and cleared in CLR.
  - In WAIT with credit=1, the counter counts idle cycles; any coin_evt resets it.
  - When the count reaches TIMEOUT_CYCLES, next state is REFUND.
  - REFUND: refund_o=1, busy_o=1 for one cycle, then CLR.
- Undefined: no REFUND state, no credit flag, refund_o tied 0; WAIT waits indefinitely.

Decomposition:
- Package vending_pkg:
  - state_e enum {CLR, WAIT, ADD, DISP, REFUND}; the REFUND encoding is always present.
  - Localparam for the default DISP_CYCLES.
- Sub-module coin_sync: 2-flop synchronizer plus rising-edge detector. Inputs clk_i, rst_ni, async_i; output pulse_o. Reusable for other board buttons.
- The controller FSM and counter stay in vending_ctrl.

Test Plan:
- Reset release, tb datapath with price s=50, a=25, coin_i=0: tot_clr_o=1 during reset and first cycle; then WAIT, all outputs 0.
- Two coins (coin_i high 10 cycles each): one tot_ld_o pulse per coin, 3 cycles after coin_i rise.
  - After the second coin, total=50 -> disp_o high exactly 4 cycles, then one tot_clr_o cycle, total=0.
- coin_i held high 100 cycles: exactly one tot_ld_o pulse; total=25, no dispense.
- Coin inserted during DISP: no tot_ld_o, total=0 after CLR, no spurious second vend.
- rst_ni pulsed low during the 2nd DISP cycle: disp_o=0 immediately; tot_clr_o=1; WAIT after release.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=20: one coin then idle.
  - refund_o pulses once, 20 cycles into WAIT; followed by tot_clr_o.
  - Without the macro: refund_o stays 0 for 1000 cycles.
